// File: rtl/req_prio_pkg.sv
// Shared constants and helpers for the request priority encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package req_prio_pkg;

    localparam int DEFAULT_N = 8;

    // Width needed to encode n distinct values, never less than 1 bit.
    function automatic int clog2_safe(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // Number of set bits in a vector of up to 64 lines. Callers zero-extend
    // narrower vectors and cast the result down to their own count width.
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/req_prio_encoder_prio_pick.sv
// Find-first-set over an N-bit mask, searching upward from start and wrapping.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   mask  - candidate lines
//   start - first index examined (must be < N)
//   any   - at least one mask bit set
//   idx   - first set index at or after start, wrapping; 0 when any=0
module prio_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    output logic         any,
    output logic [W-1:0] idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            // start + i is below 2N, so one conditional subtract wraps it.
            j = int'(start) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && mask[j]) begin
                any = 1'b1;
                idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/req_prio_encoder.sv
// Sticky request capture serialised onto a binary index, one per handshake.
// Latency: req_i at edge t -> pending after t -> valid_o/code_o after t+1.
// Backpressure: valid_o/code_o hold while !ready_i; requests keep accumulating.
//
// Ports:
//   clk, rst    - rising-edge clock, synchronous active-high reset
//   en          - capture/issue enable; when low, req_i ignored, no new loads
//   req_i       - N request lines (pulses or levels), merged into pending
//   ready_i     - consumer accepts code_o this cycle
//   valid_o     - code_o holds a served index
//   code_o      - index of the served request
//   pending_o   - requests waiting and not yet presented
//   pend_cnt_o  - number of bits set in pending_o
//   multi_o     - more than one request pending
// Build option: define ROUND_ROBIN_EN to rotate the search start past the
// last served index; otherwise index 0 always has highest priority.
module req_prio_encoder
    import req_prio_pkg::*;
#(
    parameter int N = DEFAULT_N,
    localparam int W = clog2_safe(N),
    localparam int CW = clog2_safe(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [W-1:0]  code_o,
    output logic [N-1:0]  pending_o,
    output logic [CW-1:0] pend_cnt_o,
    output logic          multi_o
);

    logic [N-1:0] pend_q, pend_d;
    logic         valid_q, valid_d;
    logic [W-1:0] code_q, code_d;

    logic         load;
    logic         pick_any;
    logic [W-1:0] pick_idx;
    logic [W-1:0] pick_start;
    logic [N-1:0] sel_oh;

    // Output slot is free when empty or being consumed this cycle.
    assign load   = !valid_q || ready_i;
    assign sel_oh = N'(1) << pick_idx;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] last_q, last_d;

    // Reset value N-1 makes the very first search begin at index 0.
    assign pick_start = (last_q == W'(N - 1)) ? '0 : last_q + W'(1);
`else
    assign pick_start = '0;
`endif

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .mask  (pend_q),
        .start (pick_start),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_comb begin
        pend_d  = pend_q;
        valid_d = valid_q;
        code_d  = code_q;
`ifdef ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        if (en) begin
            if (load) begin
                if (pick_any) begin
                    valid_d = 1'b1;
                    code_d  = pick_idx;
                    // Served bit is cleared before merging req_i, so a
                    // same-edge re-request of it is kept as a new request.
                    pend_d  = (pend_q & ~sel_oh) | req_i;
`ifdef ROUND_ROBIN_EN
                    last_d  = pick_idx;
`endif
                end else begin
                    valid_d = 1'b0;
                    code_d  = '0;
                    pend_d  = pend_q | req_i;
                end
            end else begin
                pend_d = pend_q | req_i;
            end
        end else if (valid_q && ready_i) begin
            // Disabled: a presented code may still drain, nothing new loads.
            valid_d = 1'b0;
            code_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
`ifdef ROUND_ROBIN_EN
            last_q  <= W'(N - 1);
`endif
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            code_q  <= code_d;
`ifdef ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign valid_o    = valid_q;
    assign code_o     = code_q;
    assign pending_o  = pend_q;
    assign pend_cnt_o = CW'(popcount(64'(pend_q)));
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o    = |(pend_q & (pend_q - N'(1)));

endmodule
